jtag_stream_bridge: RTL and testbench

JTAG_STREAM_BRIDGE -- requirements
Module: jtag_stream_bridge

---
 rtl/jtag_stream_bridge.sv | 180 ++++++++++++++++++
 tb/tb_jtag_stream_bridge.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtag_stream_bridge.sv
// JTAG user-DR bridge: IN_WIDTH-bit write frames feed a stream FIFO, other frames read back a result register.
// Define JTAG_BRIDGE_STATUS_EN to append an 8-bit status byte {overflow, result_loaded, level} to readback.
module jtag_stream_bridge #(
    parameter int IN_WIDTH     = 8,
    parameter int RESULT_WIDTH = 16,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                    tck,
    input  logic                    rst_n,
    input  logic                    tdi,
    output logic                    tdo,
    input  logic                    test_logic_reset,
    input  logic                    run_test_idle,
    input  logic                    ir_is_user,
    input  logic                    capture_dr,
    input  logic                    shift_dr,
    input  logic                    update_dr,
    output logic [IN_WIDTH-1:0]     m_data,
    output logic                    m_valid,
    input  logic                    m_ready,
    input  logic [RESULT_WIDTH-1:0] res_data,
    input  logic                    res_valid,
    output logic                    overflow
);

    localparam int CNT_MAX = RESULT_WIDTH + IN_WIDTH + 8;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int PW      = $clog2(FIFO_DEPTH);
    localparam int LW      = $clog2(FIFO_DEPTH + 1);
`ifdef JTAG_BRIDGE_STATUS_EN
    localparam int OUT_W   = RESULT_WIDTH + 8;
`else
    localparam int OUT_W   = RESULT_WIDTH;
`endif

    generate
        if (IN_WIDTH == RESULT_WIDTH) begin : g_badWidths
            $error("jtag_stream_bridge: IN_WIDTH must differ from RESULT_WIDTH");
        end
        if (IN_WIDTH < 2) begin : g_badInWidth
            $error("jtag_stream_bridge: IN_WIDTH must be at least 2");
        end
        if (FIFO_DEPTH < 2 || FIFO_DEPTH > 256 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_badDepth
            $error("jtag_stream_bridge: FIFO_DEPTH must be a power of two in 2..256");
        end
    endgenerate

    logic [CW-1:0]           r_count;
    logic [IN_WIDTH-1:0]     r_inSr;
    logic [OUT_W-1:0]        r_outSr;
    logic [RESULT_WIDTH-1:0] r_result;
    logic                    r_overflow;
    logic [PW-1:0]           r_wrPtr;
    logic [PW-1:0]           r_rdPtr;
    logic [LW-1:0]           r_level;
    logic [IN_WIDTH-1:0]     r_mem [FIFO_DEPTH];

    logic w_capture;
    logic w_shift;
    logic w_update;
    logic w_push;
    logic w_pop;
    logic w_full;
    logic w_accept;
    logic w_drop;
    logic w_unusedIdle;

    // DR strobes only count while the user instruction is selected.
    assign w_capture    = ir_is_user & capture_dr;
    assign w_shift      = ir_is_user & shift_dr;
    assign w_update     = ir_is_user & update_dr;
    assign w_unusedIdle = run_test_idle;

    assign w_push   = w_update & (r_count == CW'(IN_WIDTH));
    assign w_pop    = m_valid & m_ready;
    assign w_full   = (r_level == LW'(FIFO_DEPTH));
    assign w_accept = w_push & (~w_full | w_pop);
    assign w_drop   = w_push & w_full & ~w_pop;

    assign m_valid  = (r_level != '0);
    assign m_data   = r_mem[r_rdPtr];
    assign overflow = r_overflow;
    assign tdo      = ir_is_user & r_outSr[0];

    always_ff @(posedge tck or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
            r_inSr  <= '0;
        end else if (test_logic_reset) begin
            r_count <= '0;
            r_inSr  <= '0;
        end else if (w_capture) begin
            r_count <= '0;
        end else if (w_shift) begin
            r_inSr <= {tdi, r_inSr[IN_WIDTH-1:1]};
            if (r_count != CW'(CNT_MAX)) begin
                r_count <= r_count + CW'(1);
            end
        end
    end

`ifdef JTAG_BRIDGE_STATUS_EN
    logic       r_resultLoaded;
    logic [5:0] w_levelSat;

    assign w_levelSat = (int'(r_level) > 63) ? 6'd63 : 6'(r_level);

    always_ff @(posedge tck or negedge rst_n) begin
        if (!rst_n) begin
            r_resultLoaded <= 1'b0;
        end else if (test_logic_reset) begin
            r_resultLoaded <= 1'b0;
        end else if (res_valid) begin
            r_resultLoaded <= 1'b1;
        end
    end

    logic [OUT_W-1:0] w_captureWord;
    assign w_captureWord = {r_overflow, r_resultLoaded, w_levelSat, r_result};
`else
    logic [OUT_W-1:0] w_captureWord;
    assign w_captureWord = r_result;
`endif

    // Capture sees the pre-edge result, so a coincident res_valid lands in the next frame.
    always_ff @(posedge tck or negedge rst_n) begin
        if (!rst_n) begin
            r_result <= '0;
            r_outSr  <= '0;
        end else if (test_logic_reset) begin
            r_result <= '0;
            r_outSr  <= '0;
        end else begin
            if (res_valid) begin
                r_result <= res_data;
            end
            if (w_capture) begin
                r_outSr <= w_captureWord;
            end else if (w_shift) begin
                r_outSr <= {1'b0, r_outSr[OUT_W-1:1]};
            end
        end
    end

    always_ff @(posedge tck or negedge rst_n) begin
        if (!rst_n) begin
            r_wrPtr    <= '0;
            r_rdPtr    <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
        end else if (test_logic_reset) begin
            r_wrPtr    <= '0;
            r_rdPtr    <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_accept) begin
                r_wrPtr <= r_wrPtr + PW'(1);
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + PW'(1);
            end
            if (w_accept && !w_pop) begin
                r_level <= r_level + LW'(1);
            end else if (!w_accept && w_pop) begin
                r_level <= r_level - LW'(1);
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge tck) begin
        if (w_accept && !test_logic_reset) begin
            r_mem[r_wrPtr] <= r_inSr;
        end
    end

endmodule

// File: tb/tb_jtag_stream_bridge.sv
// Self-checking bench for jtag_stream_bridge: scoreboard of pushed payloads, readback and reset scenarios.
module tb_jtag_stream_bridge;

`ifdef JTAG_BRIDGE_STATUS_EN
    localparam int OUT_W = 24;
`else
    localparam int OUT_W = 16;
`endif

    logic        tck = 1'b0;
    logic        rst_n;
    logic        tdi;
    logic        tdo;
    logic        test_logic_reset;
    logic        run_test_idle;
    logic        ir_is_user;
    logic        capture_dr;
    logic        shift_dr;
    logic        update_dr;
    logic [7:0]  m_data;
    logic        m_valid;
    logic        m_ready;
    logic [15:0] res_data;
    logic        res_valid;
    logic        overflow;

    int         nChecks = 0;
    int         nFails  = 0;
    logic [7:0] expQ [$];
    logic       expOverflow;

    jtag_stream_bridge dut (
        .tck(tck), .rst_n(rst_n), .tdi(tdi), .tdo(tdo),
        .test_logic_reset(test_logic_reset), .run_test_idle(run_test_idle),
        .ir_is_user(ir_is_user), .capture_dr(capture_dr), .shift_dr(shift_dr),
        .update_dr(update_dr), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .res_data(res_data), .res_valid(res_valid), .overflow(overflow)
    );

    always #5 tck = ~tck;

    // Async reset pulse; the model is cleared alongside.
    task automatic applyReset();
        @(negedge tck);
        #2 rst_n = 1'b0;
        #1;
        nChecks++;
        if (tdo !== 1'b0 || m_valid !== 1'b0 || overflow !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL async_reset: tdo=%b m_valid=%b overflow=%b required 0/0/0", tdo, m_valid, overflow);
        end
        @(negedge tck);
        rst_n = 1'b1;
        expQ.delete();
        expOverflow = 1'b0;
    endtask

    // One DR frame: capture, nbits shifts (tdo sampled before each shift edge), update.
    task automatic runFrame(input logic [31:0] val, input int nbits, input logic user,
                            input logic readyAtUpdate, input logic resAtCapture,
                            input logic [15:0] resDataAtCapture, output logic [31:0] rd);
        logic doPop;
        rd = '0;
        @(negedge tck);
        ir_is_user = user;
        capture_dr = 1'b1;
        res_valid  = resAtCapture;
        res_data   = resDataAtCapture;
        @(negedge tck);
        capture_dr = 1'b0;
        res_valid  = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            if (i < 32) rd[i] = tdo;
            shift_dr = 1'b1;
            tdi = (i < 32) ? val[i] : 1'b0;
            @(negedge tck);
        end
        shift_dr  = 1'b0;
        tdi       = 1'b0;
        update_dr = 1'b1;
        m_ready   = readyAtUpdate;
        doPop = readyAtUpdate && (expQ.size() > 0);
        if (doPop) begin
            nChecks++;
            if (m_valid !== 1'b1 || m_data !== expQ[0]) begin
                nFails++;
                $display("[TB] FAIL pop_at_update: m_valid=%b m_data=%h required 1/%h", m_valid, m_data, expQ[0]);
            end
            void'(expQ.pop_front());
        end
        if (user && nbits == 8) begin
            if (expQ.size() < 16) expQ.push_back(val[7:0]);
            else expOverflow = 1'b1;
        end
        @(negedge tck);
        update_dr  = 1'b0;
        m_ready    = 1'b0;
        ir_is_user = 1'b1;
    endtask

    // Pops every entry, comparing against the scoreboard in order.
    task automatic drainFifo(input string tag);
        int popped;
        popped = 0;
        @(negedge tck);
        m_ready = 1'b1;
        for (int k = 0; k < 40; k++) begin
            if (m_valid !== 1'b1) break;
            nChecks++;
            if (expQ.size() == 0) begin
                nFails++;
                $display("[TB] FAIL %s_extra: m_data=%h required no entry", tag, m_data);
                break;
            end
            if (m_data !== expQ[0]) begin
                nFails++;
                $display("[TB] FAIL %s_data[%0d]: m_data=%h required %h", tag, popped, m_data, expQ[0]);
            end
            void'(expQ.pop_front());
            popped++;
            @(negedge tck);
        end
        m_ready = 1'b0;
        nChecks++;
        if (expQ.size() != 0 || m_valid !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL %s_empty: left=%0d m_valid=%b required 0/0", tag, expQ.size(), m_valid);
        end
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        applyReset();
        nChecks++;
        if (tdo !== 1'b0 || m_valid !== 1'b0 || overflow !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL reset_state: tdo=%b m_valid=%b overflow=%b required 0/0/0", tdo, m_valid, overflow);
        end
        runFrame(32'h0, OUT_W, 1'b1, 1'b0, 1'b0, 16'h0, rd);
        nChecks++;
        if (rd !== 32'h0) begin
            nFails++;
            $display("[TB] FAIL reset_readback: got=%h required 0", rd);
        end
    endtask

    task automatic test_write_frames();
        logic [31:0] rd;
        runFrame(32'h31, 8, 1'b1, 1'b0, 1'b0, 16'h0, rd);
        nChecks++;
        if (m_valid !== 1'b1 || m_data !== 8'h31) begin
            nFails++;
            $display("[TB] FAIL first_push_latency: m_valid=%b m_data=%h required 1/31", m_valid, m_data);
        end
        runFrame(32'h0A, 8, 1'b1, 1'b0, 1'b0, 16'h0, rd);
        runFrame(32'h32, 8, 1'b1, 1'b0, 1'b0, 16'h0, rd);
        drainFifo("write3");
    endtask

    task automatic test_readback();
        logic [31:0] rd;
        @(negedge tck);
        res_valid = 1'b1;
        res_data  = 16'h1234;
        @(negedge tck);
        res_valid = 1'b0;
        runFrame(32'h0, 16, 1'b1, 1'b0, 1'b1, 16'hBEEF, rd);
        nChecks++;
        if (rd[15:0] !== 16'h1234) begin
            nFails++;
            $display("[TB] FAIL readback_1234: got=%h required 1234", rd[15:0]);
        end
        nChecks++;
        if (m_valid !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL readback_no_push: m_valid=%b required 0", m_valid);
        end
        runFrame(32'h0, OUT_W, 1'b1, 1'b0, 1'b0, 16'h0, rd);
        nChecks++;
        if (rd[15:0] !== 16'hBEEF || tdo !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL readback_coincident: got=%h tdo_after=%b required BEEF/0", rd[15:0], tdo);
        end
    endtask

    task automatic test_frame_lengths();
        logic [31:0] rd;
        runFrame(32'hFF, 7, 1'b1, 1'b0, 1'b0, 16'h0, rd);
        runFrame(32'h1FF, 9, 1'b1, 1'b0, 1'b0, 16'h0, rd);
        runFrame(32'hFF, 72, 1'b1, 1'b0, 1'b0, 16'h0, rd);
        nChecks++;
        if (m_valid !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL odd_length_push: m_valid=%b required 0", m_valid);
        end
    endtask

    task automatic test_overflow();
        logic [31:0] rd;
        applyReset();
        for (int f = 0; f < 17; f++) runFrame(32'(8'h40 + f), 8, 1'b1, 1'b0, 1'b0, 16'h0, rd);
        nChecks++;
        if (overflow !== expOverflow || expOverflow !== 1'b1) begin
            nFails++;
            $display("[TB] FAIL overflow_set: overflow=%b required 1", overflow);
        end
        drainFifo("full16");
        nChecks++;
        if (overflow !== 1'b1) begin
            nFails++;
            $display("[TB] FAIL overflow_sticky: overflow=%b required 1", overflow);
        end
        applyReset();
        for (int f = 0; f < 16; f++) runFrame(32'(8'h80 + f), 8, 1'b1, 1'b0, 1'b0, 16'h0, rd);
        runFrame(32'h99, 8, 1'b1, 1'b1, 1'b0, 16'h0, rd);
        nChecks++;
        if (overflow !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL overflow_with_pop: overflow=%b required 0", overflow);
        end
        drainFifo("fullpop");
    endtask

    task automatic test_midframe_reset();
        logic [31:0] rd;
        @(negedge tck);
        capture_dr = 1'b1;
        @(negedge tck);
        capture_dr = 1'b0;
        for (int i = 0; i < 5; i++) begin
            shift_dr = 1'b1;
            tdi = 1'b1;
            @(negedge tck);
        end
        shift_dr = 1'b0;
        applyReset();
        for (int i = 0; i < 3; i++) begin
            shift_dr = 1'b1;
            tdi = 1'b1;
            @(negedge tck);
        end
        shift_dr  = 1'b0;
        update_dr = 1'b1;
        @(negedge tck);
        update_dr = 1'b0;
        runFrame(32'hA5, 8, 1'b1, 1'b0, 1'b0, 16'h0, rd);
        drainFifo("rstmid");
        runFrame(32'h3C, 8, 1'b1, 1'b0, 1'b0, 16'h0, rd);
        @(negedge tck);
        capture_dr = 1'b1;
        @(negedge tck);
        capture_dr = 1'b0;
        for (int i = 0; i < 8; i++) begin
            shift_dr = 1'b1;
            tdi = 1'b0;
            test_logic_reset = (i == 4);
            @(negedge tck);
        end
        test_logic_reset = 1'b0;
        shift_dr  = 1'b0;
        update_dr = 1'b1;
        @(negedge tck);
        update_dr = 1'b0;
        expQ.delete();
        nChecks++;
        if (m_valid !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL tlr_midframe: m_valid=%b required 0", m_valid);
        end
    endtask

    task automatic test_non_user();
        logic [31:0] rd;
        @(negedge tck);
        res_valid = 1'b1;
        res_data  = 16'hFFFF;
        @(negedge tck);
        res_valid = 1'b0;
        runFrame(32'h0, 0, 1'b1, 1'b0, 1'b0, 16'h0, rd);
        runFrame(32'hFF, 8, 1'b0, 1'b0, 1'b0, 16'h0, rd);
        nChecks++;
        if (rd[7:0] !== 8'h00 || m_valid !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL non_user: tdo_bits=%h m_valid=%b required 00/0", rd[7:0], m_valid);
        end
    endtask

`ifdef JTAG_BRIDGE_STATUS_EN
    task automatic test_status();
        logic [31:0] rd;
        applyReset();
        @(negedge tck);
        res_valid = 1'b1;
        res_data  = 16'h0007;
        @(negedge tck);
        res_valid = 1'b0;
        for (int f = 0; f < 17; f++) runFrame(32'(f), 8, 1'b1, 1'b0, 1'b0, 16'h0, rd);
        runFrame(32'h0, 24, 1'b1, 1'b0, 1'b0, 16'h0, rd);
        nChecks++;
        if (rd[23:0] !== 24'hD00007) begin
            nFails++;
            $display("[TB] FAIL status_readback: got=%h required D00007", rd[23:0]);
        end
        drainFifo("status");
    endtask
`endif

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst_n = 1'b1;
        tdi = 1'b0;
        test_logic_reset = 1'b0;
        run_test_idle = 1'b0;
        ir_is_user = 1'b1;
        capture_dr = 1'b0;
        shift_dr = 1'b0;
        update_dr = 1'b0;
        m_ready = 1'b0;
        res_data = 16'h0;
        res_valid = 1'b0;
        expOverflow = 1'b0;
        test_reset();
        test_write_frames();
        test_readback();
        test_frame_lengths();
        test_overflow();
        test_midframe_reset();
        test_non_user();
`ifdef JTAG_BRIDGE_STATUS_EN
        test_status();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFails);
        $finish;
    end

endmodule
